req_ack_4ph_rx: RTL and testbench

Receiving end of the 4-phase req/ack bundled-data crossing. It synchronizes the incoming req into clk_rx, captures the bundled data bus into a one-entry holding register and raises ack. It completes the return-to-zero phase and presents captured words downstream on a val/rdy interface. It pairs with the 4-phase transmitter, which sits in the tx clock domain.

---
 rtl/req_ack_4ph_pkg.sv | 24 ++
 rtl/sync_bit.sv | 31 +++
 rtl/req_ack_4ph_rx.sv | 104 ++++++++++
 tb/tb_req_ack_4ph_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/req_ack_4ph_pkg.sv
// ============================================================================
// Module : req_ack_4ph_pkg
// Brief  : Shared types and constants for the 4-phase req/ack crossing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package req_ack_4ph_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rx_state_e;

  localparam int SYNC_STAGES_MIN = 2;

  // Fewer than two flops gives no real metastability protection.
  function automatic int clamp_sync_stages(input int n);
    return (n < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_bit.sv
// ============================================================================
// Module : sync_bit
// Brief  : Single-bit multi-flop synchronizer with synchronous reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/req_ack_4ph_rx.sv
// ============================================================================
// Module : req_ack_4ph_rx
// Brief  : 4-phase bundled-data receiver; one-entry holding register, val/rdy out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module req_ack_4ph_rx
  import req_ack_4ph_pkg::*;
#(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_rx,
  input  logic          rst,
  input  logic          req,
  input  logic [DW-1:0] din,
  output logic          ack,
  output logic          val,
  input  logic          rdy,
  output logic [DW-1:0] dout,
  output logic          busy
);

  localparam int STAGES = clamp_sync_stages(SYNC_STAGES);

  rx_state_e     state_q, state_d;
  logic          ack_q, ack_d;
  logic          val_q, val_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          req_s;
  logic          hold_free;
  logic          capture;

  sync_bit #(
    .STAGES (STAGES)
  ) u_req_sync (
    .clk_i (clk_rx),
    .rst_i (rst),
    .d_i   (req),
    .q_o   (req_s)
  );

  // A word leaving this same edge frees the slot for the incoming one.
  assign hold_free = !val_q || rdy;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    val_d   = val_q;
    dout_d  = dout_q;
    capture = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_s && hold_free) begin
          capture = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // din is only read once req_s is high, when bundling keeps it stable.
    if (capture) begin
      dout_d = din;
      val_d  = 1'b1;
    end else if (val_q && rdy) begin
      val_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_rx) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      val_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      val_q   <= val_d;
      dout_q  <= dout_d;
    end
  end

  assign ack  = ack_q;
  assign val  = val_q;
  assign dout = dout_q;
  assign busy = (state_q != ST_IDLE) || val_q;

endmodule

`default_nettype wire

// File: tb/tb_req_ack_4ph_rx.sv
// ============================================================================
// Module : tb_req_ack_4ph_rx
// Brief  : Directed and randomized self-checking bench for req_ack_4ph_rx.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_req_ack_4ph_rx;

  localparam int DW = 8;

  logic          clk_rx;
  logic          rst;
  logic          req;
  logic [DW-1:0] din;
  logic          ack;
  logic          val;
  logic          rdy;
  logic [DW-1:0] dout;
  logic          busy;

  int checks;
  int errors;

  req_ack_4ph_rx #(
    .DW          (DW),
    .SYNC_STAGES (2)
  ) dut (
    .clk_rx (clk_rx),
    .rst    (rst),
    .req    (req),
    .din    (din),
    .ack    (ack),
    .val    (val),
    .rdy    (rdy),
    .dout   (dout),
    .busy   (busy)
  );

  initial clk_rx = 1'b0;
  always #5 clk_rx = ~clk_rx;

  task automatic step();
    @(posedge clk_rx);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Stream reference model state: words offered by the tx model, in order.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;
  logic [DW-1:0] word;
  logic          xfer;
  logic          prev_ack, prev_val, prev_rdy;
  logic          tx_s1, tx_s2;
  int            sent, rcvd, cyc, ratio, tx_phase, tx_wait;

  initial begin
    checks = 0;
    errors = 0;

    // Reset held three edges with req already high.
    rst = 1'b1; req = 1'b1; din = 8'h5A; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ack",  ack,  0);
      chk("rst_val",  val,  0);
      chk("rst_busy", busy, 0);
      chk("rst_dout", dout, 0);
    end
    rst = 1'b0;
    step(); chk("rel_val1", val, 0);
    step(); chk("rel_val2", val, 0);
    step(); chk("rel_val3", val, 1); chk("rel_ack3", ack, 1); chk("rel_dout", dout, 8'h5A);
    rdy = 1'b1; req = 1'b0;
    step(); chk("rel_drain", val, 0);
    step();
    step(); chk("rel_ackfall", ack, 0);

    // Single transfer.
    din = 8'hA5; rdy = 1'b1; req = 1'b1;
    step(); chk("st_val1", val, 0);
    step(); chk("st_val2", val, 0);
    step(); chk("st_val3", val, 1); chk("st_dout", dout, 8'hA5);
            chk("st_ack3", ack, 1); chk("st_busy", busy, 1);
    step(); chk("st_val4", val, 0); chk("st_ack4", ack, 1);
    req = 1'b0;
    step(); chk("st_ackf1", ack, 1);
    step(); chk("st_ackf2", ack, 1);
    step(); chk("st_ackf3", ack, 0); chk("st_idle_busy", busy, 0);

    // Back-pressure: holding register full, second request must wait.
    rdy = 1'b0; din = 8'h11; req = 1'b1;
    repeat (3) step();
    chk("bp_val1", val, 1); chk("bp_dout1", dout, 8'h11); chk("bp_ack1", ack, 1);
    req = 1'b0;
    repeat (3) step();
    chk("bp_ackf", ack, 0); chk("bp_hold", val, 1);
    din = 8'h22; req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_wait_ack",  ack,  0);
      chk("bp_wait_dout", dout, 8'h11);
      chk("bp_wait_val",  val,  1);
    end
    rdy = 1'b1;
    step(); chk("bp_swap_val", val, 1); chk("bp_swap_dout", dout, 8'h22); chk("bp_swap_ack", ack, 1);
    rdy = 1'b0;
    step(); chk("bp_keep_val", val, 1); chk("bp_keep_dout", dout, 8'h22);
    rdy = 1'b1;
    step(); chk("bp_drain", val, 0);
    req = 1'b0;
    repeat (3) step();
    chk("bp_ack_end", ack, 0);

    // Reset while in ST_ACK with req high.
    rdy = 1'b0; din = 8'h33; req = 1'b1;
    repeat (3) step();
    chk("ra_ack_pre", ack, 1);
    rst = 1'b1;
    step(); chk("ra_ack", ack, 0); chk("ra_val", val, 0); chk("ra_busy", busy, 0); chk("ra_dout", dout, 0);
    rst = 1'b0;
    step(); chk("ra_val1", val, 0);
    step(); chk("ra_val2", val, 0);
    step(); chk("ra_val3", val, 1); chk("ra_ack3", ack, 1); chk("ra_dout3", dout, 8'h33);
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ra_once_val", val, 0);
      chk("ra_once_ack", ack, 1);
    end
    req = 1'b0;
    step();
    step(); chk("ra_ackf2", ack, 1);
    step(); chk("ra_ackf3", ack, 0);

    // Slow req release.
    din = 8'h44; rdy = 1'b1; req = 1'b1;
    repeat (3) step();
    chk("sr_val", val, 1); chk("sr_dout", dout, 8'h44); chk("sr_ack", ack, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("sr_hold_ack", ack, 1);
      chk("sr_no_dup",   val, 0);
    end
    req = 1'b0;
    step(); chk("sr_ackf1", ack, 1);
    step(); chk("sr_ackf2", ack, 1);
    step(); chk("sr_ackf3", ack, 0); chk("sr_busy", busy, 0);

    // Randomized stream from a 4-phase tx model in a slower tx clock.
    ratio    = $urandom_range(1, 4);
    tx_phase = 0;
    tx_wait  = $urandom_range(0, 3);
    tx_s1    = 1'b0;
    tx_s2    = 1'b0;
    sent = 0; rcvd = 0; cyc = 0;
    prev_ack = ack;
    while (rcvd < 16 && cyc < 4000) begin
      rdy      = 1'($urandom_range(0, 1));
      xfer     = val && rdy;
      word     = dout;
      prev_val = val;
      prev_rdy = rdy;
      step();
      cyc++;

      if (xfer) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
        chk("stream_word", word, exp_w);
        rcvd++;
      end
      if (!prev_ack && ack) begin
        chk("stream_ack_bp", 32'(prev_val && !prev_rdy), 0);
      end
      prev_ack = ack;

      // tx domain acts only on its own edges and sees ack through two flops.
      if (cyc % ratio == 0) begin
        tx_s2 = tx_s1;
        tx_s1 = ack;
        case (tx_phase)
          0: begin
            if (tx_wait > 0) begin
              tx_wait--;
            end else if (sent < 16) begin
              din      = DW'(sent);
              tx_phase = 1;
            end
          end
          1: begin
            req = 1'b1;
            exp_q.push_back(DW'(sent));
            sent++;
            tx_phase = 2;
          end
          2: begin
            if (tx_s2) begin
              req      = 1'b0;
              tx_phase = 3;
            end
          end
          default: begin
            if (!tx_s2) begin
              tx_wait  = $urandom_range(0, 3);
              tx_phase = 0;
            end
          end
        endcase
      end
    end
    chk("stream_timeout", 32'(cyc < 4000), 1);
    chk("stream_count",   rcvd, 16);
    rdy = 1'b1;
    repeat (8) step();
    chk("stream_no_extra", val, 0);
    chk("stream_q_empty",  exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
